// File: rtl/option_packet_fifo_if.sv
// Handshake/bus bundle between the packet deserialiser (master) and the option packet FIFO (slave).
interface option_packet_fifo_if #(
    parameter int FIELD_W    = 32,
    parameter int NUM_FIELDS = 7,
    parameter int DEPTH      = 4
);
    localparam int PKT_W = FIELD_W * NUM_FIELDS;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clear;
    logic             en;
    logic             BS_READY;
    logic [PKT_W-1:0] inD;
    logic [PKT_W-1:0] out_data;
    logic             hasUnusedData;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             overflow;

    modport master (
        output clear, en, BS_READY, inD,
        input  out_data, hasUnusedData, count, full, overflow
    );

    modport slave (
        input  clear, en, BS_READY, inD,
        output out_data, hasUnusedData, count, full, overflow
    );
endinterface

// File: rtl/option_packet_fifo.sv
// DEPTH-entry circular buffer of option packets, popped on each BS_READY rising edge.
// Define OPTION_PKT_FIFO_OVERWRITE_EN to overwrite the oldest entry on a write into a full buffer.
module option_packet_fifo #(
    parameter int FIELD_W    = 32,
    parameter int NUM_FIELDS = 7,
    parameter int DEPTH      = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    option_packet_fifo_if.slave  bus
);
    localparam int PKT_W = FIELD_W * NUM_FIELDS;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [PKT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_prev_bs;
    logic             r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_lost;
    logic w_wr;
    logic w_adv_rd;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_C);
    assign w_pop   = bus.BS_READY & ~r_prev_bs & ~w_empty;
    assign w_push  = bus.en & (~w_full | w_pop);
    assign w_lost  = bus.en & ~w_push;

`ifdef OPTION_PKT_FIFO_OVERWRITE_EN
    // When full, wr_ptr == rd_ptr, so writing and advancing both replaces the oldest entry.
    assign w_wr     = (w_push | w_lost) & ~bus.clear;
    assign w_adv_rd = (w_pop | w_lost) & ~bus.clear;
`else
    assign w_wr     = w_push & ~bus.clear;
    assign w_adv_rd = w_pop & ~bus.clear;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_prev_bs  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_prev_bs <= bus.BS_READY;
            if (bus.clear) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_wr)
                    r_wr_ptr <= next_ptr(r_wr_ptr);
                if (w_adv_rd)
                    r_rd_ptr <= next_ptr(r_rd_ptr);
                if (w_push && !w_pop)
                    r_count <= r_count + CNT_W'(1);
                else if (w_pop && !w_push)
                    r_count <= r_count - CNT_W'(1);
                if (w_lost)
                    r_overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: it is only visible through count != 0.
    always_ff @(posedge clock) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= bus.inD;
    end

    assign bus.out_data      = w_empty ? '0 : r_mem[r_rd_ptr];
    assign bus.hasUnusedData = ~w_empty;
    assign bus.count         = r_count;
    assign bus.full          = w_full;
    assign bus.overflow      = r_overflow;
endmodule

// File: tb/tb_option_packet_fifo.sv
// Directed bench for option_packet_fifo with a queue-based reference model checked every cycle.
module tb_option_packet_fifo;
    localparam int FW    = 32;
    localparam int NF    = 7;
    localparam int DEPTH = 4;
    localparam int PKT_W = FW * NF;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;

    option_packet_fifo_if #(.FIELD_W(FW), .NUM_FIELDS(NF), .DEPTH(DEPTH)) bus ();

    option_packet_fifo #(.FIELD_W(FW), .NUM_FIELDS(NF), .DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [PKT_W-1:0] m_q [$];
    logic             m_ovf  = 1'b0;
    logic             m_prev = 1'b0;
    bit               chk_en = 1'b0;

    // Field k of packet n holds {k, n}; field 0 sits in the MSBs.
    function automatic logic [PKT_W-1:0] pkt(input int n);
        logic [PKT_W-1:0] p;
        p = '0;
        for (int k = 0; k < NF; k++)
            p[(NF-k)*FW-1 -: FW] = FW'((k << 16) | n);
        return p;
    endfunction

    task automatic check(input string name, input logic [PKT_W-1:0] act, input logic [PKT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_step(input logic clr, input logic e, input logic rdy,
                                       input logic [PKT_W-1:0] d);
        logic rise;
        rise   = rdy & ~m_prev;
        m_prev = rdy;
        if (clr) begin
            m_q.delete();
            m_ovf = 1'b0;
            return;
        end
        if (rise && m_q.size() != 0)
            void'(m_q.pop_front());
        if (e) begin
            if (m_q.size() < DEPTH)
                m_q.push_back(d);
            else begin
                m_ovf = 1'b1;
`ifdef OPTION_PKT_FIFO_OVERWRITE_EN
                void'(m_q.pop_front());
                m_q.push_back(d);
`endif
            end
        end
    endfunction

    always @(negedge clock) begin
        if (chk_en) begin
            logic [PKT_W-1:0] exp_head;
            exp_head = (m_q.size() != 0) ? m_q[0] : '0;
            check("model out_data", bus.out_data, exp_head);
            check("model count", PKT_W'(bus.count), PKT_W'(m_q.size()));
            check("model hasUnusedData", PKT_W'(bus.hasUnusedData), PKT_W'(m_q.size() != 0));
            check("model full", PKT_W'(bus.full), PKT_W'(m_q.size() == DEPTH));
            check("model overflow", PKT_W'(bus.overflow), PKT_W'(m_ovf));
        end
    end

    task automatic cycle(input logic clr, input logic e, input logic rdy, input logic [PKT_W-1:0] d);
        bus.clear    = clr;
        bus.en       = e;
        bus.BS_READY = rdy;
        bus.inD      = d;
        @(posedge clock);
        model_step(clr, e, rdy, d);
        @(negedge clock);
        $display("txn clr=%0d en=%0d rdy=%0d d.lo=%h -> count=%0d head.lo=%h ovf=%0d",
                 clr, e, rdy, d[FW-1:0], bus.count, bus.out_data[FW-1:0], bus.overflow);
    endtask

    task automatic pulse();
        cycle(1'b0, 1'b0, 1'b1, '0);
        cycle(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic fill_1_to_4();
        for (int i = 1; i <= 4; i++)
            cycle(1'b0, 1'b1, 1'b0, pkt(i));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PKT_W-1:0] exp_v;
        bus.clear = 1'b0; bus.en = 1'b0; bus.BS_READY = 1'b0; bus.inD = '0;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        check("reset count", PKT_W'(bus.count), '0);
        check("reset out_data", bus.out_data, '0);
        check("reset hasUnusedData", PKT_W'(bus.hasUnusedData), '0);
        check("reset full", PKT_W'(bus.full), '0);
        check("reset overflow", PKT_W'(bus.overflow), '0);

        fill_1_to_4();
        check("fill full", PKT_W'(bus.full), PKT_W'(1));
        check("fill count", PKT_W'(bus.count), PKT_W'(4));
        check("packing field6", PKT_W'(bus.out_data[FW-1:0]), PKT_W'(32'h0006_0001));
        check("packing field0", PKT_W'(bus.out_data[PKT_W-1 -: FW]), PKT_W'(32'h0000_0001));

        cycle(1'b0, 1'b1, 1'b0, pkt(5));
        check("overflow count", PKT_W'(bus.count), PKT_W'(4));
        check("overflow flag", PKT_W'(bus.overflow), PKT_W'(1));
`ifdef OPTION_PKT_FIFO_OVERWRITE_EN
        check("overwrite head", bus.out_data, pkt(2));
`else
        check("overflow head", bus.out_data, pkt(1));
`endif

        cycle(1'b1, 1'b1, 1'b0, pkt(9));
        check("clear count", PKT_W'(bus.count), '0);
        check("clear overflow", PKT_W'(bus.overflow), '0);
        check("clear out_data", bus.out_data, '0);

        fill_1_to_4();
        for (int i = 0; i < 4; i++) begin
            pulse();
            exp_v = (i < 3) ? pkt(i + 2) : '0;
            check("drain head", bus.out_data, exp_v);
        end
        check("drain hasUnusedData", PKT_W'(bus.hasUnusedData), '0);

        fill_1_to_4();
        cycle(1'b0, 1'b1, 1'b1, pkt(6));
        check("pop+push head", bus.out_data, pkt(2));
        check("pop+push count", PKT_W'(bus.count), PKT_W'(4));
        check("pop+push overflow", PKT_W'(bus.overflow), '0);
        cycle(1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            pulse();
            exp_v = (i == 0) ? pkt(3) : (i == 1) ? pkt(4) : (i == 2) ? pkt(6) : '0;
            check("tail drain head", bus.out_data, exp_v);
        end

        cycle(1'b0, 1'b1, 1'b0, pkt(11));
        cycle(1'b0, 1'b1, 1'b0, pkt(12));
        for (int i = 0; i < 10; i++)
            cycle(1'b0, 1'b0, 1'b1, '0);
        check("held ready count", PKT_W'(bus.count), PKT_W'(1));
        check("held ready head", bus.out_data, pkt(12));
        cycle(1'b0, 1'b0, 1'b0, '0);
        pulse();
        cycle(1'b0, 1'b0, 1'b1, '0);
        check("empty rise count", PKT_W'(bus.count), '0);
        cycle(1'b0, 1'b1, 1'b1, pkt(7));
        check("push after empty rise count", PKT_W'(bus.count), PKT_W'(1));
        check("push after empty rise head", bus.out_data, pkt(7));
        cycle(1'b0, 1'b0, 1'b0, '0);
        pulse();
        cycle(1'b0, 1'b1, 1'b1, pkt(8));
        check("empty en+rise count", PKT_W'(bus.count), PKT_W'(1));
        check("empty en+rise head", bus.out_data, pkt(8));
        cycle(1'b0, 1'b0, 1'b0, '0);

        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 1'b1, 1'b1, pkt(21 + i));
            check("wrap head", bus.out_data, pkt(21 + i));
            check("wrap count", PKT_W'(bus.count), PKT_W'(1));
            cycle(1'b0, 1'b0, 1'b0, '0);
        end

        cycle(1'b0, 1'b1, 1'b0, pkt(40));
        cycle(1'b0, 1'b1, 1'b0, pkt(41));
        check("pre-reset count", PKT_W'(bus.count), PKT_W'(3));
        #2 reset_n = 1'b0;
        m_q.delete();
        m_ovf  = 1'b0;
        m_prev = 1'b0;
        #1;
        check("async reset count", PKT_W'(bus.count), '0);
        check("async reset out_data", bus.out_data, '0);
        check("async reset hasUnusedData", PKT_W'(bus.hasUnusedData), '0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        cycle(1'b0, 1'b1, 1'b0, pkt(50));
        check("post-reset head", bus.out_data, pkt(50));

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
